// File: rtl/riscv_trace_buffer_if.sv
// riscv_trace_buffer_if
// Drain stream of the execution-trace buffer: a valid/ready handshake that carries
// the head FIFO entry to a monitor or debug host.
//   master : trace buffer side, drives out_valid and the out_* head fields
//   slave  : consumer side, drives out_ready
// Signals: out_valid, out_ready, out_rf_we/num/data, out_mem_wr/rd/addr/data, out_ts.
interface riscv_trace_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned TS_W   = 16
);
    logic              out_valid;
    logic              out_ready;
    logic              out_rf_we;
    logic [4:0]        out_rf_num;
    logic [DATA_W-1:0] out_rf_data;
    logic              out_mem_wr;
    logic              out_mem_rd;
    logic [ADDR_W-1:0] out_mem_addr;
    logic [DATA_W-1:0] out_mem_data;
    logic [TS_W-1:0]   out_ts;

    modport master (
        output out_valid, out_rf_we, out_rf_num, out_rf_data,
        output out_mem_wr, out_mem_rd, out_mem_addr, out_mem_data, out_ts,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_rf_we, out_rf_num, out_rf_data,
        input  out_mem_wr, out_mem_rd, out_mem_addr, out_mem_data, out_ts,
        output out_ready
    );
endinterface

// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer
// Captures the single-cycle RISC-V core's register-write and data-memory trace into a
// DEPTH-deep FIFO, one entry per event cycle, and drains it over a valid/ready stream.
// The core is never stalled: events arriving while the FIFO is full are dropped and counted.
// Ports:
//   clk, reset                : rising-edge clock, synchronous active-low reset
//   enable                    : arms capture
//   reg_write_sig/reg_num/reg_data                : register-file trace
//   wr/rd/addr/wr_data/rd_data                    : data-memory trace
//   drain (riscv_trace_buffer_if.master)          : head entry + valid/ready handshake
//   count                     : occupancy
//   overflow, drop_cnt        : sticky drop flag, saturating drop counter
//   clr_ovf                   : clears overflow/drop_cnt (a drop in the same cycle wins)
// Build option: define TRACE_TIMESTAMP_EN to add a TS_W-bit cycle counter whose value is
// stored with each entry; otherwise out_ts is tied to 0.
module riscv_trace_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        rd_data,
    riscv_trace_buffer_if.master     drain,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    input  logic                     clr_ovf
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic              rf_we;
        logic [4:0]        rf_num;
        logic [DATA_W-1:0] rf_data;
        logic              mem_wr;
        logic              mem_rd;
        logic [ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_data;
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           head_q, head_d;
    entry_t           new_entry;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             valid, event_cyc, push, pop, drop;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end
`endif

    // Pack the current cycle's trace; unused fields are zeroed so entries compare cleanly.
    always_comb begin
        new_entry        = '0;
        new_entry.rf_we  = reg_write_sig;
        new_entry.mem_wr = wr;
        new_entry.mem_rd = rd;
        if (reg_write_sig) begin
            new_entry.rf_num  = reg_num;
            new_entry.rf_data = reg_data;
        end
        if (wr || rd) begin
            new_entry.mem_addr = addr;
        end
        if (wr) begin
            new_entry.mem_data = wr_data;
        end else if (rd) begin
            new_entry.mem_data = rd_data;
        end
`ifdef TRACE_TIMESTAMP_EN
        new_entry.ts = ts_q;
`endif
    end

    always_comb begin
        valid     = (count_q != '0);
        event_cyc = enable & (reg_write_sig | wr | rd);
        pop       = valid & drain.out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
        push      = event_cyc & ((count_q != FULL) | pop);
        drop      = event_cyc & (count_q == FULL) & ~pop;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end

        // Registered head: load the entry that will be at the read pointer next cycle.
        // When that slot is the one being written right now, bypass the storage array.
        // With nothing left the head keeps the last popped entry.
        head_d = head_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = new_entry;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            head_q     <= head_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

    assign drain.out_valid    = valid;
    assign drain.out_rf_we    = head_q.rf_we;
    assign drain.out_rf_num   = head_q.rf_num;
    assign drain.out_rf_data  = head_q.rf_data;
    assign drain.out_mem_wr   = head_q.mem_wr;
    assign drain.out_mem_rd   = head_q.mem_rd;
    assign drain.out_mem_addr = head_q.mem_addr;
    assign drain.out_mem_data = head_q.mem_data;
`ifdef TRACE_TIMESTAMP_EN
    assign drain.out_ts       = head_q.ts;
`else
    assign drain.out_ts       = {TS_W{1'b0}};
`endif
endmodule

// File: tb/tb_riscv_trace_buffer.sv
module tb_riscv_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_ovf;

    always #5 clk = ~clk;

    riscv_trace_buffer_if #(.DATA_W(32), .ADDR_W(9), .TS_W(16)) bus ();

    riscv_trace_buffer #(.DATA_W(32), .ADDR_W(9), .DEPTH(DEPTH), .TS_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .reg_write_sig (reg_write_sig),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .drain         (bus),
        .count         (count),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .clr_ovf       (clr_ovf)
    );

    typedef struct {
        logic        en;
        logic        rws;
        logic [4:0]  num;
        logic [31:0] data;
        logic        wr;
        logic        rd;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        e_push;
        logic        e_rf_we;
        logic [4:0]  e_num;
        logic [31:0] e_rf_data;
        logic        e_wr;
        logic        e_rd;
        logic [8:0]  e_addr;
        logic [31:0] e_mdata;
    } vec_t;

    vec_t vecs [6];

    int n_cmp = 0;
    int n_bad = 0;
    int n_popped = 0;

    // Reference model of the FIFO contents (reg_data of each stored entry) and status.
    int unsigned q [$];
    bit          ovf_m = 1'b0;
    int unsigned drop_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        enable        = 1'b1;
        reg_write_sig = 1'b0;
        reg_num       = '0;
        reg_data      = '0;
        wr            = 1'b0;
        rd            = 1'b0;
        addr          = '0;
        wr_data       = '0;
        rd_data       = '0;
    endtask

    // One clock: checks the head against the model, drives an optional register-write
    // event carrying val, then checks occupancy and overflow status after the edge.
    task automatic step(input bit ev, input logic [31:0] val, input bit ready);
        bit          popm;
        bit          dropm;
        logic [31:0] head;
        popm = 1'b0;
        chk("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            head = q[0];
            chk("head_rf_data", bus.out_rf_data, head);
            chk("head_rf_num", bus.out_rf_num, head[4:0]);
            popm = ready;
        end
        enable        = 1'b1;
        reg_write_sig = ev;
        reg_num       = val[4:0];
        reg_data      = val;
        wr            = 1'b0;
        rd            = 1'b0;
        bus.out_ready = ready;
        tick;
        if (popm) begin
            void'(q.pop_front());
            n_popped++;
        end
        dropm = 1'b0;
        if (ev) begin
            if (q.size() < DEPTH) q.push_back(val);
            else dropm = 1'b1;
        end
        if (dropm) begin
            ovf_m  = 1'b1;
            drop_m = clr_ovf ? 1 : ((drop_m == 65535) ? 65535 : drop_m + 1);
        end else if (clr_ovf) begin
            ovf_m  = 1'b0;
            drop_m = 0;
        end
        chk("count", count, q.size());
        chk("overflow", overflow, ovf_m);
        chk("drop_cnt", drop_cnt, drop_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int popped_before;

        vecs[0] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 9'h055, 32'h1, 32'h2,
                    1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 9'h000, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 5'd3, 32'h0000CAFE, 1'b1, 1'b1, 9'h1A4, 32'h11, 32'h22,
                    1'b1, 1'b1, 5'd3, 32'h0000CAFE, 1'b1, 1'b1, 9'h1A4, 32'h11};
        vecs[2] = '{1'b1, 1'b0, 5'd7, 32'h00001234, 1'b0, 1'b1, 9'h010, 32'h33, 32'h44,
                    1'b1, 1'b0, 5'd0, 32'h00000000, 1'b0, 1'b1, 9'h010, 32'h44};
        vecs[3] = '{1'b1, 1'b0, 5'd9, 32'h00000005, 1'b1, 1'b0, 9'h1FF, 32'hAA, 32'hBB,
                    1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b0, 9'h1FF, 32'hAA};
        vecs[4] = '{1'b0, 1'b1, 5'd4, 32'h00000099, 1'b1, 1'b0, 9'h001, 32'h5, 32'h6,
                    1'b0, 1'b0, 5'd0, 32'h00000000, 1'b0, 1'b0, 9'h000, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 5'd6, 32'h00000077, 1'b0, 1'b0, 9'h123, 32'h7, 32'h8,
                    1'b0, 1'b0, 5'd0, 32'h00000000, 1'b0, 1'b0, 9'h000, 32'h0};

        // Reset, then idle.
        idle_inputs();
        bus.out_ready = 1'b0;
        clr_ovf       = 1'b0;
        reset         = 1'b0;
        tick;
        tick;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_rf_data", bus.out_rf_data, 0);
        chk("rst_mem_addr", bus.out_mem_addr, 0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);

        // Directed single-entry vectors.
        for (int i = 0; i < 6; i++) begin
            enable        = vecs[i].en;
            reg_write_sig = vecs[i].rws;
            reg_num       = vecs[i].num;
            reg_data      = vecs[i].data;
            wr            = vecs[i].wr;
            rd            = vecs[i].rd;
            addr          = vecs[i].addr;
            wr_data       = vecs[i].wdata;
            rd_data       = vecs[i].rdata;
            bus.out_ready = 1'b0;
            tick;
            idle_inputs();
            chk($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].e_push);
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_push ? 1 : 0);
            if (vecs[i].e_push) begin
                chk($sformatf("vec%0d_rf_we", i), bus.out_rf_we, vecs[i].e_rf_we);
                chk($sformatf("vec%0d_rf_num", i), bus.out_rf_num, vecs[i].e_num);
                chk($sformatf("vec%0d_rf_data", i), bus.out_rf_data, vecs[i].e_rf_data);
                chk($sformatf("vec%0d_mem_wr", i), bus.out_mem_wr, vecs[i].e_wr);
                chk($sformatf("vec%0d_mem_rd", i), bus.out_mem_rd, vecs[i].e_rd);
                chk($sformatf("vec%0d_mem_addr", i), bus.out_mem_addr, vecs[i].e_addr);
                chk($sformatf("vec%0d_mem_data", i), bus.out_mem_data, vecs[i].e_mdata);
                bus.out_ready = 1'b1;
                tick;
                bus.out_ready = 1'b0;
                chk($sformatf("vec%0d_drained_count", i), count, 0);
                chk($sformatf("vec%0d_drained_valid", i), bus.out_valid, 1'b0);
            end
        end

        // Overflow: 19 events with no consumer, then drain 0..15 in order.
        for (int i = 0; i < DEPTH + 3; i++) step(1'b1, 32'(i), 1'b0);
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drop_cnt", drop_cnt, 3);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1);
        chk("ovf_drained_count", count, 0);
        clr_ovf = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        clr_ovf = 1'b0;
        chk("clr_overflow", overflow, 1'b0);
        chk("clr_drop_cnt", drop_cnt, 0);

        // Refill, drop two, then clear in the same cycle as a drop: drop wins.
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 32'(100 + i), 1'b0);
        chk("refill_drop_cnt", drop_cnt, 2);
        clr_ovf = 1'b1;
        step(1'b1, 32'd118, 1'b0);
        clr_ovf = 1'b0;
        chk("clr_vs_drop_overflow", overflow, 1'b1);
        chk("clr_vs_drop_drop_cnt", drop_cnt, 1);

        // Full push+pop keeps count at 16 and appends without a drop.
        step(1'b1, 32'd200, 1'b1);
        chk("full_pushpop_count", count, 16);
        chk("full_pushpop_drop_cnt", drop_cnt, 1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1);
        chk("full_pushpop_drained", count, 0);

        // Wrap-around stream of 40 entries with the consumer always ready.
        popped_before = n_popped;
        for (int i = 0; i < 40; i++) step(1'b1, 32'(300 + i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        chk("stream_received", n_popped - popped_before, 40);

        // Reset mid-drain discards stored entries and clears status.
        for (int i = 0; i < 3; i++) step(1'b1, 32'(400 + i), 1'b0);
        idle_inputs();
        reset = 1'b0;
        tick;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_overflow", overflow, 1'b0);
        chk("mid_rst_drop_cnt", drop_cnt, 0);
        chk("mid_rst_rf_data", bus.out_rf_data, 0);
        q.delete();
        ovf_m  = 1'b0;
        drop_m = 0;
        reset  = 1'b1;

        // Timestamps: events sampled at edges 3 and 7 after reset release.
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'd500, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'd501, 1'b0);
`ifdef TRACE_TIMESTAMP_EN
        chk("ts_first", bus.out_ts, 3);
`else
        chk("ts_first", bus.out_ts, 0);
`endif
        step(1'b0, 32'h0, 1'b1);
`ifdef TRACE_TIMESTAMP_EN
        chk("ts_second", bus.out_ts, 7);
`else
        chk("ts_second", bus.out_ts, 0);
`endif
        step(1'b0, 32'h0, 1'b1);
        chk("final_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Parametrised execution-trace capture unit for the single-cycle RISC-V core. It samples the core's per-cycle register-write and data-memory trace signals (`reg_write_sig`/`reg_num`/`reg_data`, `wr`/`rd`/`addr`/`wr_data`/`rd_data`) and packs each active cycle into one entry in a DEPTH-deep FIFO. A valid/ready port drains the FIFO to a testbench monitor or debug host. Overflow is counted rather than stalling the core.

## Interface
Parameters:
- `DATA_W`, 32: register and memory data width.
- `ADDR_W`, 9: data-memory address width.
- `DEPTH`, 16: FIFO entries; a power of two, at least 2.
- `TS_W`, 16: timestamp width (used only with `TRACE_TIMESTAMP_EN`).

Ports:
- `clk` in 1: clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-low reset.
- `enable` in 1: when 1, capture is armed.
- `reg_write_sig` in 1: core register-file write strobe.
- `reg_num` in 5: destination register.
- `reg_data` in DATA_W: write-back data.
- `wr` in 1: core memory write strobe.
- `rd` in 1: core memory read strobe.
- `addr` in ADDR_W: memory address.
- `wr_data` in DATA_W: store data.
- `rd_data` in DATA_W: load data.
- `out_valid` out 1: the head entry is available.
- `out_ready` in 1: the consumer accepts the head entry.
- `out_rf_we`, `out_rf_num`, `out_rf_data` out 1/5/DATA_W: head entry, register-file fields.
- `out_mem_wr`, `out_mem_rd`, `out_mem_addr`, `out_mem_data` out 1/1/ADDR_W/DATA_W: head entry, memory fields.
- `out_ts` out TS_W: head entry capture timestamp.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag, set when any event is dropped.
- `drop_cnt` out 16: number of dropped events, saturating.
- `clr_ovf` in 1: clears `overflow` and `drop_cnt`.

## Operation
- Event cycle: `enable & (reg_write_sig | wr | rd)`. One event cycle produces exactly one entry.
- Entry fields:
  - `rf_we = reg_write_sig`.
  - `rf_num`/`rf_data` = the inputs when `reg_write_sig` is 1, otherwise 0.
  - `mem_wr = wr`, `mem_rd = rd`.
  - `mem_addr = addr` when `wr|rd`, otherwise 0.
  - `mem_data`: `wr_data` if `wr`, else `rd_data` if `rd`, else 0. When `wr` and `rd` are both 1, `wr_data` is captured and both flags are set.
- FIFO:
  - Circular buffer with write pointer, read pointer and occupancy counter.
  - Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
- Push: an event cycle while `count < DEPTH`, or while `count == DEPTH` and a pop occurs in the same cycle.
- Pop: `out_valid & out_ready`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. This holds at full and at any other occupancy.
- Full with no pop: the event is dropped. `overflow` is set to 1 and `drop_cnt` increments, saturating at 0xFFFF.
- Empty: `out_valid` is 0 and the `out_*` fields hold the last popped values (don't-care). `out_ready` has no effect.
- `clr_ovf`:
  - Clears `overflow` and `drop_cnt` next edge.
  - If a drop happens in the same cycle, the drop wins: `overflow` = 1, `drop_cnt` = 1.
- `enable` low: no pushes. Pops continue normally.
- The block never back-pressures the core.

## Timing
- Reset (`reset` = 0 at an edge):
  - Pointers, `count`, `overflow`, `drop_cnt` = 0; `out_valid` = 0.
  - `out_*` fields = 0; timestamp counter = 0.
- Reset has priority over all other inputs. Reset mid-drain discards all stored entries.
- Latency: an event sampled at edge N is visible on `out_valid`/`out_*` after edge N, i.e. in cycle N+1 when the FIFO was empty. The head is registered in first-word-fall-through style.
- `count` and `overflow` are registered and reflect edge N effects in cycle N+1.
- The `out_*` fields are stable while `out_valid=1 & out_ready=0`.
- The timestamp counter increments every cycle after reset, wraps at 2^TS_W, and is latched into the entry at push.
- Sustained throughput is one entry per cycle.

## Configuration
- `TRACE_TIMESTAMP_EN` defined: a TS_W-bit free-running cycle counter is instantiated, each entry stores its capture value, and `out_ts` presents it.
- Not defined: no counter and no timestamp storage. `out_ts` is tied to 0. The port still exists so the bench is the same in both builds.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, release, drive no events for 10 cycles. Required: `out_valid`=0, `count`=0, `overflow`=0, `drop_cnt`=0 throughout.
- Single capture: `reg_write_sig`=1, `reg_num`=5, `reg_data`=0xDEADBEEF for one cycle. Required: `out_valid`=1 the next cycle with `out_rf_we`=1, `out_rf_num`=5, `out_rf_data`=0xDEADBEEF, `out_mem_wr`=`out_mem_rd`=0. After the pop, `count` returns to 0.
- Combined event: `wr`=`rd`=1, `addr`=0x1A4, `wr_data`=0x11, `rd_data`=0x22, with a register write in the same cycle. Required: one entry with both memory flags set, `out_mem_addr`=0x1A4, `out_mem_data`=0x11, and the register fields populated.
- Overflow: hold `out_ready`=0 and push DEPTH+3 events (values 0..18 with DEPTH=16). Required:
  - `count`=16, `overflow`=1, `drop_cnt`=3.
  - Draining yields 0..15 in order.
  - `clr_ovf` then returns both flags to 0.
- Full push+pop: at `count`=16, assert an event and `out_ready` together. Required: `count` stays 16, the new value is appended, and `drop_cnt` is unchanged. Run a wrap-around stream of 40 entries at `out_ready`=1: all 40 are received in order.
- Timestamp: with `TRACE_TIMESTAMP_EN`, events at cycles 3 and 7 after reset give `out_ts` values 3 and 7 (difference 4). Without the macro, `out_ts`=0 for both.
